// File: rtl/histogram_accum_if.sv
// Sample/readout bus of the histogram accumulator.
// master: sample source + host (drives ENA, d_in, clr, rd_en, rd_addr).
// slave : histogram_accum (drives busy, mem_out, out_valid, rd_data, rd_valid, ovf_flag).
interface histogram_accum_if #(
  parameter int unsigned AW      = 7,
  parameter int unsigned COUNT_W = 7
);
  logic               ENA;
  logic [AW-1:0]      d_in;
  logic               clr;
  logic               busy;
  logic [COUNT_W-1:0] mem_out;
  logic               out_valid;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [COUNT_W-1:0] rd_data;
  logic               rd_valid;
  logic               ovf_flag;

  modport master (
    output ENA, d_in, clr, rd_en, rd_addr,
    input  busy, mem_out, out_valid, rd_data, rd_valid, ovf_flag
  );

  modport slave (
    input  ENA, d_in, clr, rd_en, rd_addr,
    output busy, mem_out, out_valid, rd_data, rd_valid, ovf_flag
  );
endinterface

// File: rtl/histogram_accum.sv
// Per-bin occurrence counter over a single-port-write, sync-read RAM.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset; forces a full clear sweep
//   bus  - histogram_accum_if.slave: sample input (ENA/d_in), clear request
//          (clr), update result (mem_out/out_valid), random-access readout
//          (rd_en/rd_addr -> rd_data/rd_valid), busy and sticky ovf_flag.
// A sample accepted at edge k reads the RAM at k+1 and writes the new count
// at k+2; the result of the previous sample is forwarded to cover the
// read-during-write at k+1.
module histogram_accum #(
  parameter int unsigned NUM_BINS = 128,
  parameter int unsigned COUNT_W  = 7,
  parameter int unsigned SAT_MODE = 1
) (
  input logic CLK,
  input logic RST,
  histogram_accum_if.slave bus
);

  localparam int unsigned AW = $clog2(NUM_BINS);
  localparam logic [COUNT_W-1:0] MAX_COUNT = '1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, next_state;
  logic [AW-1:0] clr_addr;
  logic          drain_cnt;
  logic          busy_q;

  // Update pipeline
  logic               s1_valid, s2_valid;
  logic [AW-1:0]      s1_addr, s2_addr;
  logic [COUNT_W-1:0] ram_q;
  logic [COUNT_W-1:0] mem_out_q;
  logic               out_valid_q;
  logic [AW-1:0]      last_addr;
  logic               ovf_q;

  // Readout
  logic               rd_pend;
  logic               rd_valid_q;
  logic [COUNT_W-1:0] rd_data_q;

  logic [COUNT_W-1:0] mem [NUM_BINS];

  logic               accept_c;
  logic               rd_accept_c;
  logic               enter_clear_c;
  logic               fwd_c;
  logic               at_max_c;
  logic [COUNT_W-1:0] old_c;
  logic [COUNT_W-1:0] new_c;
  logic [AW-1:0]      ram_raddr_c;
  logic               ram_we_c;
  logic [AW-1:0]      ram_waddr_c;
  logic [COUNT_W-1:0] ram_wdata_c;

  // State register; busy tracks the registered "not RUN" condition
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      drain_cnt <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state     <= next_state;
      clr_addr  <= (state == CLEAR) ? clr_addr + AW'(1) : '0;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      busy_q    <= (next_state != RUN);
    end
  end

  // Next state and RAM write port selection
  always_comb begin
    next_state    = state;
    enter_clear_c = 1'b0;
    ram_we_c      = s2_valid;
    ram_waddr_c   = s2_addr;
    ram_wdata_c   = new_c;
    case (state)
      CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = clr_addr;
        ram_wdata_c = '0;
        if (clr_addr == AW'(NUM_BINS - 1)) next_state = RUN;
      end
      RUN: begin
        if (bus.clr) next_state = DRAIN;
      end
      DRAIN: begin
        // Two cycles let the last accepted sample finish its write
        if (drain_cnt) begin
          next_state    = CLEAR;
          enter_clear_c = 1'b1;
        end
      end
      default: next_state = CLEAR;
    endcase
  end

  // Acceptance, forwarding and counter arithmetic
  always_comb begin
    accept_c    = bus.ENA && !busy_q;
    rd_accept_c = bus.rd_en && !bus.ENA && !busy_q && !s1_valid && !s2_valid;
    ram_raddr_c = rd_accept_c ? bus.rd_addr : s1_addr;
    // Previous result was written on the same edge this sample read the RAM
    fwd_c       = out_valid_q && (last_addr == s2_addr);
    old_c       = fwd_c ? mem_out_q : ram_q;
    at_max_c    = (old_c == MAX_COUNT);
    if (!at_max_c)          new_c = old_c + COUNT_W'(1);
    else if (SAT_MODE != 0) new_c = MAX_COUNT;
    else                    new_c = '0;
  end

  // Counter RAM: no reset, read-before-write on a shared address
  always_ff @(posedge CLK) begin
    if (ram_we_c) mem[ram_waddr_c] <= ram_wdata_c;
    ram_q <= mem[ram_raddr_c];
  end

  // Pipeline, result, readout and overflow registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      s2_valid    <= 1'b0;
      s2_addr     <= '0;
      mem_out_q   <= '0;
      out_valid_q <= 1'b0;
      last_addr   <= '0;
      rd_pend     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid    <= accept_c;
      s1_addr     <= bus.d_in;
      s2_valid    <= s1_valid;
      s2_addr     <= s1_addr;
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        mem_out_q <= new_c;
        last_addr <= s2_addr;
      end
      rd_pend    <= rd_accept_c;
      rd_valid_q <= rd_pend;
      if (rd_pend) rd_data_q <= ram_q;
      if (enter_clear_c)            ovf_q <= 1'b0;
      else if (s2_valid && at_max_c) ovf_q <= 1'b1;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mem_out   = mem_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_histogram_accum.sv
// Directed bench for histogram_accum: one 128x7 saturating instance plus
// 8x3 saturating and wrapping instances for the overflow cases.
module tb_histogram_accum;

  localparam int unsigned NB_A = 128;
  localparam int unsigned AW_A = 7;
  localparam int unsigned CW_A = 7;
  localparam int unsigned NB_S = 8;
  localparam int unsigned AW_S = 3;
  localparam int unsigned CW_S = 3;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   exp_a[$];
  int   exp_b[$];
  int   exp_c[$];
  int   cnt[NB_A];

  int fwd_d[13]  = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 6, 5};
  int fwd_e[13]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 1, 12};
  int sat_e[9]   = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
  int wrap_e[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  histogram_accum_if #(.AW(AW_A), .COUNT_W(CW_A)) ia ();
  histogram_accum_if #(.AW(AW_S), .COUNT_W(CW_S)) ib ();
  histogram_accum_if #(.AW(AW_S), .COUNT_W(CW_S)) ic ();

  histogram_accum #(.NUM_BINS(NB_A), .COUNT_W(CW_A), .SAT_MODE(1)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ia)
  );
  histogram_accum #(.NUM_BINS(NB_S), .COUNT_W(CW_S), .SAT_MODE(1)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ib)
  );
  histogram_accum #(.NUM_BINS(NB_S), .COUNT_W(CW_S), .SAT_MODE(0)) dut_c (
    .CLK(CLK), .RST(RST), .bus(ic)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Advance one cycle and score any update results against the queues
  task automatic tick();
    @(negedge CLK);
    if (ia.out_valid) begin
      if (exp_a.size() == 0) chk("a_out_valid", 32'(ia.out_valid), 32'(0));
      else chk("a_mem_out", 32'(ia.mem_out), 32'(exp_a.pop_front()));
    end
    if (ib.out_valid) begin
      if (exp_b.size() == 0) chk("b_out_valid", 32'(ib.out_valid), 32'(0));
      else chk("b_mem_out", 32'(ib.mem_out), 32'(exp_b.pop_front()));
    end
    if (ic.out_valid) begin
      if (exp_c.size() == 0) chk("c_out_valid", 32'(ic.out_valid), 32'(0));
      else chk("c_mem_out", 32'(ic.mem_out), 32'(exp_c.pop_front()));
    end
  endtask

  task automatic rd_a(input int addr, input int want);
    ia.rd_en   = 1'b1;
    ia.rd_addr = AW_A'(addr);
    tick();
    ia.rd_en = 1'b0;
    chk("rd_valid_early", 32'(ia.rd_valid), 32'(0));
    tick();
    chk("rd_valid", 32'(ia.rd_valid), 32'(1));
    chk($sformatf("rd_data_bin%0d", addr), 32'(ia.rd_data), 32'(want));
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    ia.ENA = 1'b0; ia.d_in = '0; ia.clr = 1'b0; ia.rd_en = 1'b0; ia.rd_addr = '0;
    ib.ENA = 1'b0; ib.d_in = '0; ib.clr = 1'b0; ib.rd_en = 1'b0; ib.rd_addr = '0;
    ic.ENA = 1'b0; ic.d_in = '0; ic.clr = 1'b0; ic.rd_en = 1'b0; ic.rd_addr = '0;
    foreach (cnt[i]) cnt[i] = 0;

    // Reset state and sweep length
    tick();
    tick();
    chk("rst_busy", 32'(ia.busy), 32'(1));
    chk("rst_out_valid", 32'(ia.out_valid), 32'(0));
    chk("rst_mem_out", 32'(ia.mem_out), 32'(0));
    chk("rst_rd_valid", 32'(ia.rd_valid), 32'(0));
    chk("rst_rd_data", 32'(ia.rd_data), 32'(0));
    chk("rst_ovf", 32'(ia.ovf_flag), 32'(0));
    RST = 1'b0;
    n = 0;
    while (ia.busy && n < 400) begin n++; tick(); end
    chk("reset_busy_cycles", 32'(n), 32'(128));
    rd_a(0, 0);
    rd_a(64, 0);
    rd_a(127, 0);

    // Ramp over even bins, 16 hits each
    ia.ENA = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ia.d_in = AW_A'((2 * i) % 128);
      cnt[(2 * i) % 128]++;
      exp_a.push_back(cnt[(2 * i) % 128]);
      tick();
    end
    ia.ENA = 1'b0;
    tick(); tick(); tick();
    chk("ramp_pending", 32'(exp_a.size()), 32'(0));
    chk("ramp_last_mem_out", 32'(ia.mem_out), 32'(16));
    chk("ramp_ovf", 32'(ia.ovf_flag), 32'(0));
    for (int b = 0; b < 128; b++) rd_a(b, (b % 2 == 0) ? 16 : 0);

    // Clear mid-stream: clr on the 20th sample, ENA held through the sweep
    ia.ENA  = 1'b1;
    ia.d_in = AW_A'(9);
    for (int i = 1; i <= 20; i++) begin
      ia.clr = (i == 20);
      exp_a.push_back(i);
      tick();
    end
    ia.clr = 1'b0;
    n = 0;
    while (ia.busy && n < 400) begin n++; tick(); end
    ia.ENA = 1'b0;
    chk("clear_busy_cycles", 32'(n), 32'(130));
    chk("clear_pending", 32'(exp_a.size()), 32'(0));
    chk("clear_last_mem_out", 32'(ia.mem_out), 32'(20));
    chk("clear_ovf", 32'(ia.ovf_flag), 32'(0));
    rd_a(9, 0);
    rd_a(8, 0);

    // Same-bin forwarding, back-to-back and one apart
    ia.ENA = 1'b1;
    for (int i = 0; i < 13; i++) begin
      ia.d_in = AW_A'(fwd_d[i]);
      exp_a.push_back(fwd_e[i]);
      tick();
    end
    ia.ENA = 1'b0;
    tick(); tick(); tick();
    chk("fwd_pending", 32'(exp_a.size()), 32'(0));

    // Sample and read in the same cycle: the read is dropped
    ia.ENA = 1'b1; ia.d_in = AW_A'(5);
    ia.rd_en = 1'b1; ia.rd_addr = AW_A'(6);
    exp_a.push_back(13);
    tick();
    ia.ENA = 1'b0; ia.rd_en = 1'b0;
    chk("arb_rd_valid_1", 32'(ia.rd_valid), 32'(0));
    tick();
    chk("arb_rd_valid_2", 32'(ia.rd_valid), 32'(0));
    tick();
    chk("arb_pending", 32'(exp_a.size()), 32'(0));
    rd_a(5, 13);
    rd_a(6, 1);

    // Saturate vs wrap on 3-bit counters
    ib.ENA = 1'b1; ib.d_in = AW_S'(3);
    ic.ENA = 1'b1; ic.d_in = AW_S'(3);
    for (int i = 0; i < 9; i++) begin
      exp_b.push_back(sat_e[i]);
      exp_c.push_back(wrap_e[i]);
      tick();
    end
    chk("sat_ovf_before", 32'(ib.ovf_flag), 32'(0));
    chk("wrap_ovf_before", 32'(ic.ovf_flag), 32'(0));
    ib.ENA = 1'b0; ic.ENA = 1'b0;
    tick();
    chk("sat_ovf_8th", 32'(ib.ovf_flag), 32'(1));
    chk("wrap_ovf_8th", 32'(ic.ovf_flag), 32'(1));
    tick(); tick();
    chk("sat_pending", 32'(exp_b.size()), 32'(0));
    chk("wrap_pending", 32'(exp_c.size()), 32'(0));

    // Clear sweep drops the sticky flag on the saturating instance only
    ib.clr = 1'b1;
    tick();
    ib.clr = 1'b0;
    n = 0;
    while (ib.busy && n < 100) begin n++; tick(); end
    chk("b_clear_busy_cycles", 32'(n), 32'(10));
    chk("b_ovf_after_clear", 32'(ib.ovf_flag), 32'(0));
    chk("c_ovf_sticky", 32'(ic.ovf_flag), 32'(1));

    // Reset one cycle after a sample: update lost, full sweep, no residue
    ia.ENA = 1'b1; ia.d_in = AW_A'(20);
    tick();
    ia.ENA = 1'b0;
    RST = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(ia.out_valid), 32'(0));
    chk("rst_mid_mem_out", 32'(ia.mem_out), 32'(0));
    chk("rst_mid_busy", 32'(ia.busy), 32'(1));
    chk("rst_mid_c_ovf", 32'(ic.ovf_flag), 32'(0));
    tick();
    RST = 1'b0;
    n = 0;
    while (ia.busy && n < 400) begin n++; tick(); end
    chk("rst_mid_busy_cycles", 32'(n), 32'(128));
    rd_a(20, 0);
    rd_a(5, 0);
    chk("rst_mid_pending", 32'(exp_a.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_accum.md
Name: histogram_accum

Overview:
- Parametrised successor to histogram_unit. Counts occurrences of each input sample value in a RAM of per-bin counters.
- Adds a configurable bin count and counter width, a saturate/wrap mode, and a sticky overflow flag.
- Adds a hazard-free read-modify-write pipeline with same-bin forwarding, a hardware clear sweep, and a random-access readout port.
- Sits after the sample source in the statistics path; a host reads bins out once the stream has stopped.

Parameters:
NUM_BINS, 128, number of bins; d_in/rd_addr width AW = $clog2(NUM_BINS); must be a power of two >= 4
COUNT_W, 7, width of each bin counter
SAT_MODE, 1, 1 = counters saturate at 2^COUNT_W-1; 0 = counters wrap to 0

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
ENA  input  1  sample enable
d_in  input  AW  sample value (bin index)
clr  input  1  request a clear sweep (single-cycle pulse)
busy  output  1  high while clearing or draining; samples and reads are ignored while high
mem_out  output  COUNT_W  updated count of the bin hit by the sample accepted 2 cycles earlier
out_valid  output  1  qualifies mem_out
rd_en  input  1  readout request
rd_addr  input  AW  readout bin index
rd_data  output  COUNT_W  readout count
rd_valid  output  1  qualifies rd_data, 1 cycle after an accepted read
ovf_flag  output  1  sticky flag: some bin saturated (SAT_MODE=1) or wrapped (SAT_MODE=0)

Behaviour:
- Counter RAM has no reset. It uses synchronous read and is written once per cycle.
- RST asserted: all outputs 0 immediately; pipeline flushed; FSM forced to CLEAR with sweep address 0; busy=1.
- FSM states are CLEAR, RUN and DRAIN.
  - CLEAR: writes 0 to bin addr, addr++ each cycle. Lasts NUM_BINS cycles after RST deasserts, then goes to RUN; busy drops on the edge that writes the last bin.
  - RUN: a sample is accepted on an edge where ENA=1 and busy=0.
  - clr in RUN: go to DRAIN with busy=1 from the next cycle. Samples already in the pipeline complete. After 2 cycles go to CLEAR. ovf_flag clears on entry to CLEAR.
  - clr while busy: ignored.
- Update pipeline for a sample accepted at edge k:
  - edge k+1: RAM read issued.
  - edge k+2: new count written to RAM; mem_out and out_valid=1 registered.
  - out_valid is 0 in every cycle without a result.
- Forwarding: back-to-back or 1-apart samples to the same bin use the in-flight value, not stale RAM data. Each mem_out equals the total number of accepted samples to that bin since the last clear, including the current one, subject to the SAT_MODE rule.
- Arithmetic:
  - SAT_MODE=1: at 2^COUNT_W-1 the count holds and ovf_flag sets.
  - SAT_MODE=0: 2^COUNT_W-1 goes to 0 and ovf_flag sets.
  - ovf_flag is cleared only by RST or a clear sweep.
- Readout:
  - rd_en is accepted only when ENA=0, busy=0 and the pipeline is empty (no out_valid pending in the next 2 cycles); otherwise ignored.
  - An accepted read gives rd_data = bin count and rd_valid=1 on the next edge.
  - rd_data holds until the next accepted read or RST.
- ENA and rd_en in the same cycle: the sample wins and the read is dropped.
- RST mid-update: the in-flight update is lost, then a full sweep runs; no partial counts survive.

Test Plan:
- Reset sweep, NUM_BINS=128: RST 1 cycle -> busy=1 for exactly 128 cycles; then reads of bins 0, 64 and 127 return 0 with rd_valid 1 cycle after rd_en.
- Ramp, COUNT_W=7: ENA=1, d_in starts at 0 and increments by 2 mod 128 for 1024 samples.
  - mem_out on the n-th sample to a bin is n; last mem_out = 16.
  - Readout gives 16 on even bins and 0 on odd bins; ovf_flag=0.
- Forwarding: d_in=5 for 10 consecutive cycles, then 5, 6, 5 -> mem_out 1..10, then 11, 1, 12 on consecutive valid cycles.
- Saturation, COUNT_W=3:
  - SAT_MODE=1, 9 samples of bin 3 -> mem_out 1..7,7,7; ovf_flag sets on the 8th sample.
  - SAT_MODE=0 -> mem_out ..., 7, 0, 1; ovf_flag sets.
- Clear mid-stream: 20 samples of bin 9, then clr with ENA held -> last mem_out 20 after drain; busy for 2+128 cycles; samples during busy are not counted; readout of bin 9 = 0; ovf_flag=0.
- Read arbitration / RST mid-update:
  - ENA and rd_en in the same cycle -> rd_valid stays 0.
  - RST asserted 1 cycle after a sample -> out_valid never rises; full sweep runs; bin reads 0.
